register_file: RTL and testbench

Eight-entry, 16-bit general-purpose register file with an integrated processor status word (PSW) register. It sits directly downstream of `control_unit`. It resolves the `GPR_select` code against instruction fields, drives the internal data bus on `GPR_out`, and captures the bus on `GPR_in`. It also produces the `PSW_bits` (N, Z) that `control_unit` consumes for conditional branches. R7 is the program counter.

---
 rtl/fpg8_pkg.sv | 33 +++
 rtl/gpr_index_decode.sv | 43 ++++
 rtl/register_file.sv | 68 ++++++
 tb/tb_register_file.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fpg8_pkg.sv
// Shared constants for the fpg8 datapath: GPR select codes, instruction field
// positions, PSW bit indices and the register-index decode payload.
package fpg8_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned PSW_W   = 2;

    localparam logic [2:0] GPR_SEL_ZERO = 3'b000;
    localparam logic [2:0] GPR_SEL_PC   = 3'b001;
    localparam logic [2:0] GPR_SEL_RD1  = 3'b010;
    localparam logic [2:0] GPR_SEL_RD2  = 3'b011;
    localparam logic [2:0] GPR_SEL_RS1  = 3'b100;
    localparam logic [2:0] GPR_SEL_RS2  = 3'b101;

    localparam logic [IDX_W-1:0] PC_INDEX = 3'd7;

    // Low bit of each 3-bit register field inside the instruction word
    localparam int unsigned RD1_LSB = 3;
    localparam int unsigned RD2_LSB = 9;
    localparam int unsigned RS1_LSB = 6;
    localparam int unsigned RS2_LSB = 0;

    localparam int unsigned PSW_N = 1;
    localparam int unsigned PSW_Z = 0;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] index;
        logic             psw_update;
    } gpr_decode_t;

endpackage

// File: rtl/gpr_index_decode.sv
// Maps a GPR select code plus the current instruction word to a register
// index, a valid flag and whether a write through it updates the PSW.
module gpr_index_decode
    import fpg8_pkg::*;
(
    input  logic [2:0]         gpr_select,
    input  logic [INSTR_W-1:0] instruction,
    output gpr_decode_t        decode_c
);

    // Opcode bits carry no register field
    logic unused_opcode;
    assign unused_opcode = ^instruction[INSTR_W-1:12];

    always_comb begin
        decode_c = '0;
        case (gpr_select)
            GPR_SEL_PC: begin
                decode_c.valid = 1'b1;
                decode_c.index = PC_INDEX;
            end
            GPR_SEL_RD1: begin
                decode_c.valid      = 1'b1;
                decode_c.index      = instruction[RD1_LSB +: IDX_W];
                decode_c.psw_update = 1'b1;
            end
            GPR_SEL_RD2: begin
                decode_c.valid = 1'b1;
                decode_c.index = instruction[RD2_LSB +: IDX_W];
            end
            GPR_SEL_RS1: begin
                decode_c.valid = 1'b1;
                decode_c.index = instruction[RS1_LSB +: IDX_W];
            end
            GPR_SEL_RS2: begin
                decode_c.valid = 1'b1;
                decode_c.index = instruction[RS2_LSB +: IDX_W];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/register_file.sv
// Eight-entry GPR file (R7 = PC) with N/Z status register.
// Define REGFILE_R0_ZERO_EN to hardwire R0 to zero.
module register_file
    import fpg8_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NUM_REGS = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               GPR_in,
    input  logic               GPR_out,
    input  logic [2:0]         GPR_select,
    input  logic [DATA_W-1:0]  bus_in,
    output logic [DATA_W-1:0]  bus_out,
    output logic [PSW_W-1:0]   PSW_bits,
    output logic [DATA_W-1:0]  pc_value
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [PSW_W-1:0]  psw_q;
    gpr_decode_t       dec;
    logic              wr_en;
    logic [DATA_W-1:0] rd_data;

    gpr_index_decode u_decode (
        .gpr_select (GPR_select),
        .instruction(instruction),
        .decode_c   (dec)
    );

    // R0 hardwiring masks both the write enable and the read data
    always_comb begin
        wr_en   = GPR_in && dec.valid;
        rd_data = regs[dec.index];
`ifdef REGFILE_R0_ZERO_EN
        if (dec.index == '0) begin
            wr_en   = 1'b0;
            rd_data = '0;
        end
`else
`endif
    end

    // Register and PSW update; reset wins over any pending write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
            psw_q <= '0;
        end else begin
            if (wr_en) begin
                regs[dec.index] <= bus_in;
            end
            if (GPR_in && dec.psw_update) begin
                psw_q[PSW_N] <= bus_in[DATA_W-1];
                psw_q[PSW_Z] <= (bus_in == '0);
            end
        end
    end

    assign bus_out  = (GPR_out && dec.valid) ? rd_data : '0;
    assign PSW_bits = psw_q;
    assign pc_value = regs[PC_INDEX];

endmodule

// File: tb/tb_register_file.sv
// Directed plan plus randomized traffic for register_file, checked against an
// array-based reference model of the register file and PSW.
module tb_register_file;

    logic        clk;
    logic        reset;
    logic [15:0] instruction;
    logic        GPR_in;
    logic        GPR_out;
    logic [2:0]  GPR_select;
    logic [15:0] bus_in;
    logic [15:0] bus_out;
    logic [1:0]  PSW_bits;
    logic [15:0] pc_value;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_regs [8];
    logic [1:0]  m_psw;

`ifdef REGFILE_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    register_file dut (
        .clk        (clk),
        .reset      (reset),
        .instruction(instruction),
        .GPR_in     (GPR_in),
        .GPR_out    (GPR_out),
        .GPR_select (GPR_select),
        .bus_in     (bus_in),
        .bus_out    (bus_out),
        .PSW_bits   (PSW_bits),
        .pc_value   (pc_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, got, exp, $time);
        end
    endtask

    // Register named by a select code; returns -1 for the constant-zero codes
    function automatic int resolve(input logic [2:0] sel, input logic [15:0] ins);
        int v;
        v = int'(ins);
        if (sel == 3'd1) return 7;
        if (sel == 3'd2) return (v / 8) % 8;
        if (sel == 3'd3) return (v / 512) % 8;
        if (sel == 3'd4) return (v / 64) % 8;
        if (sel == 3'd5) return v % 8;
        return -1;
    endfunction

    function automatic logic [15:0] model_read(input int idx);
        if (idx < 0) return 16'h0000;
        if (R0_ZERO && idx == 0) return 16'h0000;
        return m_regs[idx];
    endfunction

    task automatic model_check();
        int idx;
        idx = resolve(GPR_select, instruction);
        check("bus_out", bus_out, GPR_out ? model_read(idx) : 16'h0000);
        check("psw", 16'(PSW_bits), 16'(m_psw));
        check("pc_value", pc_value, m_regs[7]);
    endtask

    task automatic model_update();
        int idx;
        if (reset) begin
            foreach (m_regs[i]) m_regs[i] = 16'h0000;
            m_psw = 2'b00;
        end else if (GPR_in) begin
            idx = resolve(GPR_select, instruction);
            if (idx >= 0 && !(R0_ZERO && idx == 0)) m_regs[idx] = bus_in;
            if (GPR_select == 3'd2) m_psw = {bus_in[15], bus_in == 16'h0000};
        end
    endtask

    task automatic apply(input logic [15:0] ins, input logic [2:0] sel, input logic gin,
                         input logic gout, input logic [15:0] bin, input logic rst);
        @(negedge clk);
        instruction = ins;
        GPR_select  = sel;
        GPR_in      = gin;
        GPR_out     = gout;
        bus_in      = bin;
        reset       = rst;
        #1;
        model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
    endtask

    initial begin
        foreach (m_regs[i]) m_regs[i] = 16'hDEAD;
        m_psw = 2'b11;
        reset = 1'b1; instruction = '0; GPR_in = 0; GPR_out = 0; GPR_select = '0; bus_in = '0;
        @(posedge clk);
        model_update();

        // Reset state
        apply(16'h0000, 3'b001, 0, 1, 16'h0000, 0);
        check("rst_bus", bus_out, 16'h0000);
        check("rst_psw", 16'(PSW_bits), 16'h0000);
        check("rst_pc", pc_value, 16'h0000);
        tick();

        // Rd_2 = 7 writes the PC, PSW untouched
        apply(16'h0E28, 3'b011, 1, 0, 16'h1234, 0);
        tick();
        apply(16'h0E28, 3'b001, 0, 1, 16'h0000, 0);
        check("jump_pc", pc_value, 16'h1234);
        check("jump_bus", bus_out, 16'h1234);
        check("jump_psw", 16'(PSW_bits), 16'h0000);
        tick();

        // Rd_1 writeback sets N, then Z
        apply(16'h0008, 3'b010, 1, 0, 16'h8000, 0);
        tick();
        apply(16'h0008, 3'b010, 0, 1, 16'h0000, 0);
        check("r1_val", bus_out, 16'h8000);
        check("psw_n", 16'(PSW_bits), 16'h0002);
        tick();
        apply(16'h0008, 3'b010, 1, 0, 16'h0000, 0);
        tick();
        apply(16'h0008, 3'b010, 0, 1, 16'h0000, 0);
        check("psw_z", 16'(PSW_bits), 16'h0001);
        tick();

        // Read-before-write on R2
        apply(16'h0010, 3'b010, 1, 0, 16'h0055, 0);
        tick();
        apply(16'h0010, 3'b010, 1, 1, 16'h00AA, 0);
        check("rbw_old", bus_out, 16'h0055);
        tick();
        apply(16'h0010, 3'b010, 0, 1, 16'h0000, 0);
        check("rbw_new", bus_out, 16'h00AA);
        tick();

        // Reserved select: no write, reads zero
        apply(16'h0010, 3'b110, 1, 1, 16'hFFFF, 0);
        check("rsv_bus", bus_out, 16'h0000);
        tick();
        apply(16'h0010, 3'b010, 0, 1, 16'h0000, 0);
        check("rsv_r2", bus_out, 16'h00AA);
        check("rsv_psw", 16'(PSW_bits), 16'h0000);
        check("rsv_pc", pc_value, 16'h1234);
        tick();

        // Rd_1 targeting R0
        apply(16'h0000, 3'b010, 1, 0, 16'hFFFF, 0);
        tick();
        apply(16'h0000, 3'b010, 0, 1, 16'h0000, 0);
        check("r0_val", bus_out, R0_ZERO ? 16'h0000 : 16'hFFFF);
        check("r0_psw", 16'(PSW_bits), 16'h0002);
        tick();

        // Reset discards a same-cycle write
        apply(16'h0008, 3'b010, 1, 0, 16'h1111, 1);
        tick();
        apply(16'h0008, 3'b010, 0, 1, 16'h0000, 0);
        check("rst_wr_r1", bus_out, 16'h0000);
        check("rst_wr_pc", pc_value, 16'h0000);
        check("rst_wr_psw", 16'(PSW_bits), 16'h0000);
        tick();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            apply(16'($urandom), 3'($urandom_range(7)), 1'($urandom_range(1)),
                  1'($urandom_range(1)),
                  ($urandom_range(7) == 0) ? 16'h0000 : 16'($urandom),
                  $urandom_range(40) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
